// File: rtl/traffic_ctrl_timed.sv
// Two-way intersection light sequencer with a seconds prescaler, all-red clearance,
// red+yellow ready phases, early green termination on request and flashing-yellow mode.
module traffic_ctrl_timed #(
    parameter int TICK_DIV    = 50000000,
    parameter int T_GREEN     = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_MIN_GREEN = 10,
    parameter int SEC_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flash,
    input  logic             ped_req,
    output logic             ns_red,
    output logic             ns_yellow,
    output logic             ns_green,
    output logic             ew_red,
    output logic             ew_yellow,
    output logic             ew_green,
    output logic [3:0]       state,
    output logic [SEC_W-1:0] phase_sec
);

    typedef enum logic [3:0] {
        OFF      = 4'd0,
        NS_READY = 4'd1,
        NS_GO    = 4'd2,
        NS_STOP  = 4'd3,
        AR_NS    = 4'd4,
        EW_READY = 4'd5,
        EW_GO    = 4'd6,
        EW_STOP  = 4'd7,
        AR_EW    = 4'd8,
        FLASH    = 4'd9
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    P_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0] G_LAST  = SEC_W'(T_GREEN - 1);
    localparam logic [SEC_W-1:0] Y_LAST  = SEC_W'(T_YELLOW - 1);
    localparam logic [SEC_W-1:0] AR_LAST = SEC_W'(T_ALLRED - 1);
    localparam logic [SEC_W:0]   MIN_G   = (SEC_W + 1)'(T_MIN_GREEN);
    localparam logic [SEC_W-1:0] SEC_MAX = '1;

    state_t           state_reg, state_next;
    logic [PW-1:0]    presc_reg, presc_next;
    logic [SEC_W-1:0] sec_reg, sec_next;
    logic             ped_pending_reg, ped_pending_next;
    logic             blink_reg, blink_next;

    logic tick;
    logic green_done;
    logic yellow_done;
    logic allred_done;

    assign tick        = (presc_reg == P_LAST);
    assign yellow_done = tick && (sec_reg == Y_LAST);
    assign allred_done = tick && (sec_reg == AR_LAST);
    // A pending request may cut the green short once the minimum green has elapsed.
    assign green_done  = tick && ((sec_reg == G_LAST) ||
                         (ped_pending_reg && (({1'b0, sec_reg} + (SEC_W + 1)'(1)) >= MIN_G)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= OFF;
            presc_reg       <= '0;
            sec_reg         <= '0;
            ped_pending_reg <= 1'b0;
            blink_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            presc_reg       <= presc_next;
            sec_reg         <= sec_next;
            ped_pending_reg <= ped_pending_next;
            blink_reg       <= blink_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = OFF;
        end else if (flash) begin
            state_next = FLASH;
        end else begin
            case (state_reg)
                OFF:      state_next = AR_EW;
                AR_EW:    if (allred_done) state_next = NS_READY;
                NS_READY: if (yellow_done) state_next = NS_GO;
                NS_GO:    if (green_done)  state_next = NS_STOP;
                NS_STOP:  if (yellow_done) state_next = AR_NS;
                AR_NS:    if (allred_done) state_next = EW_READY;
                EW_READY: if (yellow_done) state_next = EW_GO;
                EW_GO:    if (green_done)  state_next = EW_STOP;
                EW_STOP:  if (yellow_done) state_next = AR_EW;
                FLASH:    state_next = AR_EW;
                default:  state_next = OFF;
            endcase
        end
    end

    // Timers restart on every state change so each phase lasts exactly T*TICK_DIV cycles.
    always_comb begin
        presc_next = presc_reg;
        sec_next   = sec_reg;
        if (state_next != state_reg) begin
            presc_next = '0;
            sec_next   = '0;
        end else if (tick) begin
            presc_next = '0;
            if (sec_reg != SEC_MAX) begin
                sec_next = sec_reg + SEC_W'(1);
            end
        end else begin
            presc_next = presc_reg + PW'(1);
        end
    end

    always_comb begin
        ped_pending_next = ped_pending_reg;
        if (state_reg == OFF || state_reg == FLASH) begin
            ped_pending_next = 1'b0;
        end else if (ped_req) begin
            ped_pending_next = 1'b1;
        end else if ((state_reg == NS_GO || state_reg == EW_GO) && green_done) begin
            ped_pending_next = 1'b0;
        end
    end

    always_comb begin
        blink_next = blink_reg;
        if (state_reg != FLASH) begin
            blink_next = (state_next == FLASH);
        end else if (tick) begin
            blink_next = ~blink_reg;
        end
    end

    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        case (state_reg)
            NS_READY: begin ns_red = 1'b1; ns_yellow = 1'b1; ew_red = 1'b1; end
            NS_GO:    begin ns_green = 1'b1; ew_red = 1'b1; end
            NS_STOP:  begin ns_yellow = 1'b1; ew_red = 1'b1; end
            AR_NS,
            AR_EW:    begin ns_red = 1'b1; ew_red = 1'b1; end
            EW_READY: begin ew_red = 1'b1; ew_yellow = 1'b1; ns_red = 1'b1; end
            EW_GO:    begin ew_green = 1'b1; ns_red = 1'b1; end
            EW_STOP:  begin ew_yellow = 1'b1; ns_red = 1'b1; end
            FLASH:    begin ns_yellow = blink_reg; ew_yellow = blink_reg; end
            default:  ;
        endcase
    end

    assign state     = state_reg;
    assign phase_sec = sec_reg;

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// Directed bench for traffic_ctrl_timed: phase durations, lamp decode, early green exit,
// flashing mode, enable drop and asynchronous reset.
module tb_traffic_ctrl_timed;

    localparam int SEC_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             flash;
    logic             ped_req;
    logic             ns_red, ns_yellow, ns_green;
    logic             ew_red, ew_yellow, ew_green;
    logic [3:0]       state;
    logic [SEC_W-1:0] phase_sec;
    logic [5:0]       lamps;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

    traffic_ctrl_timed #(
        .TICK_DIV   (4),
        .T_GREEN    (5),
        .T_YELLOW   (2),
        .T_ALLRED   (1),
        .T_MIN_GREEN(2),
        .SEC_W      (SEC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .flash    (flash),
        .ped_req  (ped_req),
        .ns_red   (ns_red),
        .ns_yellow(ns_yellow),
        .ns_green (ns_green),
        .ew_red   (ew_red),
        .ew_yellow(ew_yellow),
        .ew_green (ew_green),
        .state    (state),
        .phase_sec(phase_sec)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    function automatic logic [5:0] lamp_exp(input logic [3:0] s);
        case (s)
            4'd1:    return 6'b110100;
            4'd2:    return 6'b001100;
            4'd3:    return 6'b010100;
            4'd4:    return 6'b100100;
            4'd5:    return 6'b100110;
            4'd6:    return 6'b100001;
            4'd7:    return 6'b100010;
            4'd8:    return 6'b100100;
            default: return 6'b000000;
        endcase
    endfunction

    // Called at a negedge inside state s; counts the cycles remaining in s.
    task automatic measure(input string tag, input logic [3:0] s, input int exp_dur,
                           input int exp_last);
        int dur;
        logic [SEC_W-1:0] last;
        dur  = 0;
        last = '0;
        check({tag, "_state"}, 32'(state), 32'(s));
        check({tag, "_lamps"}, 32'(lamps), 32'(lamp_exp(s)));
        while (state == s && dur < 200) begin
            last = phase_sec;
            dur++;
            @(negedge clk);
        end
        check({tag, "_dur"}, 32'(dur), 32'(exp_dur));
        check({tag, "_lastsec"}, 32'(last), 32'(exp_last));
    endtask

    initial begin
        int n;
        rst     = 1'b0;
        enable  = 1'b1;
        flash   = 1'b0;
        ped_req = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_lamps", 32'(lamps), 32'd0);
        check("rst_sec", 32'(phase_sec), 32'd0);

        // 1: full loop
        @(negedge clk);
        rst = 1'b1;
        check("t1_off", 32'(state), 32'd0);
        @(negedge clk);
        measure("t1_ar_ew", 4'd8, 4, 0);
        measure("t1_ns_ready", 4'd1, 8, 1);
        measure("t1_ns_go", 4'd2, 20, 4);
        measure("t1_ns_stop", 4'd3, 8, 1);
        measure("t1_ar_ns", 4'd4, 4, 0);
        measure("t1_ew_ready", 4'd5, 8, 1);
        measure("t1_ew_go", 4'd6, 20, 4);
        measure("t1_ew_stop", 4'd7, 8, 1);

        // 2: one-cycle request two cycles into NS_GO
        measure("t2_ar_ew", 4'd8, 4, 0);
        measure("t2_ns_ready", 4'd1, 8, 1);
        repeat (2) @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        measure("t2_ns_go_rest", 4'd2, 5, 1);
        measure("t2_ns_stop", 4'd3, 8, 1);
        measure("t2_ar_ns", 4'd4, 4, 0);
        measure("t2_ew_ready", 4'd5, 8, 1);
        measure("t2_ew_go", 4'd6, 20, 4);
        measure("t2_ew_stop", 4'd7, 8, 1);

        // 3: request held through the NS green exit, then dropped
        ped_req = 1'b1;
        measure("t3_ar_ew", 4'd8, 4, 0);
        measure("t3_ns_ready", 4'd1, 8, 1);
        measure("t3_ns_go", 4'd2, 8, 1);
        ped_req = 1'b0;
        measure("t3_ns_stop", 4'd3, 8, 1);
        measure("t3_ar_ns", 4'd4, 4, 0);
        measure("t3_ew_ready", 4'd5, 8, 1);
        measure("t3_ew_go", 4'd6, 8, 1);
        measure("t3_ew_stop", 4'd7, 8, 1);

        // 4: flashing mode entered from EW_GO
        measure("t4_ar_ew", 4'd8, 4, 0);
        measure("t4_ns_ready", 4'd1, 8, 1);
        measure("t4_ns_go", 4'd2, 20, 4);
        measure("t4_ns_stop", 4'd3, 8, 1);
        measure("t4_ar_ns", 4'd4, 4, 0);
        measure("t4_ew_ready", 4'd5, 8, 1);
        repeat (3) @(negedge clk);
        flash = 1'b1;
        @(negedge clk);
        check("t4_flash_state", 32'(state), 32'd9);
        check("t4_flash_on_lamps", 32'(lamps), 32'b010010);
        n = 0;
        while (state == 4'd9 && ns_yellow && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t4_blink_on_dur", 32'(n), 32'd4);
        check("t4_flash_off_lamps", 32'(lamps), 32'd0);
        n = 0;
        while (state == 4'd9 && !ns_yellow && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t4_blink_off_dur", 32'(n), 32'd4);
        flash = 1'b0;
        @(negedge clk);
        measure("t4_restart_ar_ew", 4'd8, 4, 0);
        measure("t4_ns_ready2", 4'd1, 8, 1);

        // 5: enable dropped mid NS_STOP
        measure("t5_ns_go", 4'd2, 20, 4);
        repeat (5) @(negedge clk);
        check("t5_stop_sec", 32'(phase_sec), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("t5_off_state", 32'(state), 32'd0);
        check("t5_off_lamps", 32'(lamps), 32'd0);
        check("t5_off_sec", 32'(phase_sec), 32'd0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        measure("t5_ar_ew", 4'd8, 4, 0);
        measure("t5_ns_ready", 4'd1, 8, 1);

        // 6: asynchronous reset during NS_GO with a request pending
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_state", 32'(state), 32'd0);
        check("t6_async_lamps", 32'(lamps), 32'd0);
        check("t6_async_sec", 32'(phase_sec), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t6_held_state", 32'(state), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        measure("t6_ar_ew", 4'd8, 4, 0);
        measure("t6_ns_ready", 4'd1, 8, 1);
        measure("t6_ns_go", 4'd2, 20, 4);
        measure("t6_ns_stop", 4'd3, 8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_timed.md
Name: traffic_ctrl_timed

Overview:
- Parametrised two-way intersection light controller (NS and EW approaches) with real timing.
- Each phase is held for a configurable number of seconds, derived from a clock prescaler.
- Adds an all-red clearance phase, a red+yellow "ready" phase per approach, a pedestrian/early-termination request, a flashing-yellow maintenance mode and an enable.
- Top-level light sequencer driving lamp drivers; status outputs feed a monitor/display block.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (>=1; bench uses 4)
T_GREEN, 30, green duration in seconds (>=1)
T_YELLOW, 3, duration in seconds of both the yellow (stop) and red+yellow (ready) phases (>=1)
T_ALLRED, 1, all-red clearance in seconds (>=1)
T_MIN_GREEN, 10, minimum green in seconds before a request may cut it short (1..T_GREEN)
SEC_W, 6, width of seconds counter; must hold max(T_*)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  1 = run; 0 = all lamps off
flash  in  1  1 = flashing-yellow mode (when enable=1)
ped_req  in  1  request to end the current green early (level or pulse, sampled each clk)
ns_red, ns_yellow, ns_green  out  1 each  NS lamps
ew_red, ew_yellow, ew_green  out  1 each  EW lamps
state  out  4  current state encoding
phase_sec  out  SEC_W  whole seconds elapsed in current state

Behaviour:
- Reset (rst=0, async): state=OFF, prescaler=0, phase_sec=0, ped_pending=0, blink=0; all six lamps 0.
- Prescaler counts 0..TICK_DIV-1; tick=1 in the cycle it equals TICK_DIV-1. On tick, phase_sec increments. Both the prescaler and phase_sec clear on every state change, so a T-second phase lasts exactly T*TICK_DIV cycles.
- State encoding:
  - OFF=0
  - NS_READY=1 (NS red+yellow, EW red)
  - NS_GO=2 (NS green, EW red)
  - NS_STOP=3 (NS yellow, EW red)
  - AR_NS=4 (all red)
  - EW_READY=5 (EW red+yellow, NS red)
  - EW_GO=6
  - EW_STOP=7
  - AR_EW=8 (all red)
  - FLASH=9
- Lamps are a pure decode of state (and blink in FLASH). They change in the same cycle state changes. Every unlisted lamp is 0.
- Priority, evaluated every clk, highest first:
  1. enable=0 -> OFF.
  2. flash=1 -> FLASH.
  3. Normal sequence.
- Normal sequence, each exit taken on tick when phase_sec == T-1:
  - OFF -> AR_EW, taken on the first clk with enable=1 and flash=0.
  - AR_EW -> NS_READY (T_ALLRED)
  - NS_READY -> NS_GO (T_YELLOW)
  - NS_GO -> NS_STOP (green exit rule, below)
  - NS_STOP -> AR_NS (T_YELLOW)
  - AR_NS -> EW_READY (T_ALLRED)
  - EW_READY -> EW_GO
  - EW_GO -> EW_STOP (green exit rule)
  - EW_STOP -> AR_EW
  - Never transitions directly between a green and the opposing green/ready.
- Green exit: on tick, if phase_sec == T_GREEN-1, OR (ped_pending=1 AND phase_sec+1 >= T_MIN_GREEN).
- ped_pending:
  - Set by ped_req=1 in any state except OFF/FLASH.
  - Cleared in the cycle a green exits. If ped_req=1 in that same cycle, set wins and stays pending for the next green.
  - Cleared in OFF and FLASH.
- FLASH:
  - On entry blink=1. blink toggles on every tick.
  - ns_yellow = ew_yellow = blink; all other lamps 0.
  - On flash deassert -> AR_EW (safe restart, all red first).
- enable=0 mid-phase: OFF next cycle; timers cleared; no sequence memory kept. Re-enable restarts at AR_EW.
- Illegal state codes -> OFF next cycle.
- phase_sec saturates at its max and never wraps.
- Reset mid-operation: immediate (async) return to reset values.

Test Plan:
Parameters for all scenarios: TICK_DIV=4, T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_MIN_GREEN=2.
1. Release rst with enable=1, flash=0 -> OFF for 1 cycle, then state sequence 8,1,2,3,4,5,6,7,8 lasting 4,8,20,8,4,8,20,8 cycles respectively. Full loop is 80 cycles; lamps are one-hot/red+yellow exactly per the decode.
2. Pulse ped_req 1 cycle, 2 cycles into NS_GO -> NS_GO exits after 8 cycles (phase_sec 1 at tick) instead of 20. ped_pending is 0 afterwards. EW_GO runs the full 20 cycles.
3. Hold ped_req=1 continuously -> every green lasts 8 cycles; a request coincident with a green exit keeps ped_pending=1.
4. flash=1 during EW_GO -> next cycle state=9, both yellows=1 for 4 cycles then 0 for 4, other lamps 0. Deassert flash -> AR_EW (all red) for 4 cycles, then NS_READY.
5. enable=0 mid-NS_STOP -> all lamps 0 the next cycle, phase_sec=0. enable=1 -> AR_EW, then the sequence resumes from NS_READY.
6. Assert rst asynchronously between clk edges during NS_GO -> lamps 0 and state=0 immediately, without waiting for a clk edge. ped_pending is cleared.
